// File: rtl/mesh_element_hs.sv
// Mesh tile: four fixed-route directional channels, each through its own
// DEPTH-entry valid/ready FIFO, plus the serial LSB chain with one registered tap.

// Handshake (all channels): a word moves on a rising edge when valid && ready
// are both high in the preceding cycle. in_ready and out_valid come only from
// registered state, so neither side sees a combinational path through the tile.
module mesh_element_hs_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_bits_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             out_bits_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  assign in_ready_o  = (count_q != FULL);
  assign out_valid_o = (count_q != '0);
  assign out_bits_o  = mem_q[rd_ptr_q];
  assign occ_o       = count_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= in_bits_i;
    end
  end
endmodule

module mesh_element_hs #(
  parameter int WIDTH      = 64,
  parameter int DEPTH      = 2,
  parameter int LSB_CHAINS = 8,
  parameter int LSB_TAP    = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        io_ins_down_valid,
  output logic                        io_ins_down_ready,
  input  logic [WIDTH-1:0]            io_ins_down_bits,
  input  logic                        io_ins_right_valid,
  output logic                        io_ins_right_ready,
  input  logic [WIDTH-1:0]            io_ins_right_bits,
  input  logic                        io_ins_up_valid,
  output logic                        io_ins_up_ready,
  input  logic [WIDTH-1:0]            io_ins_up_bits,
  input  logic                        io_ins_left_valid,
  output logic                        io_ins_left_ready,
  input  logic [WIDTH-1:0]            io_ins_left_bits,
  output logic                        io_outs_down_valid,
  input  logic                        io_outs_down_ready,
  output logic [WIDTH-1:0]            io_outs_down_bits,
  output logic                        io_outs_right_valid,
  input  logic                        io_outs_right_ready,
  output logic [WIDTH-1:0]            io_outs_right_bits,
  output logic                        io_outs_up_valid,
  input  logic                        io_outs_up_ready,
  output logic [WIDTH-1:0]            io_outs_up_bits,
  output logic                        io_outs_left_valid,
  input  logic                        io_outs_left_ready,
  output logic [WIDTH-1:0]            io_outs_left_bits,
  output logic [$clog2(DEPTH+1)-1:0]  io_occ_down,
  output logic [$clog2(DEPTH+1)-1:0]  io_occ_right,
  output logic [$clog2(DEPTH+1)-1:0]  io_occ_up,
  output logic [$clog2(DEPTH+1)-1:0]  io_occ_left,
  input  logic [LSB_CHAINS-1:0]       io_lsbIns,
  output logic [LSB_CHAINS-1:0]       io_lsbOuts
);
  // Each output is fed by the input arriving from the opposite-turned side.
  mesh_element_hs_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_down_to_left (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (io_ins_down_valid),
    .in_ready_o (io_ins_down_ready),
    .in_bits_i  (io_ins_down_bits),
    .out_valid_o(io_outs_left_valid),
    .out_ready_i(io_outs_left_ready),
    .out_bits_o (io_outs_left_bits),
    .occ_o      (io_occ_left)
  );

  mesh_element_hs_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_right_to_up (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (io_ins_right_valid),
    .in_ready_o (io_ins_right_ready),
    .in_bits_i  (io_ins_right_bits),
    .out_valid_o(io_outs_up_valid),
    .out_ready_i(io_outs_up_ready),
    .out_bits_o (io_outs_up_bits),
    .occ_o      (io_occ_up)
  );

  mesh_element_hs_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_up_to_right (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (io_ins_up_valid),
    .in_ready_o (io_ins_up_ready),
    .in_bits_i  (io_ins_up_bits),
    .out_valid_o(io_outs_right_valid),
    .out_ready_i(io_outs_right_ready),
    .out_bits_o (io_outs_right_bits),
    .occ_o      (io_occ_right)
  );

  mesh_element_hs_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_left_to_down (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_valid_i (io_ins_left_valid),
    .in_ready_o (io_ins_left_ready),
    .in_bits_i  (io_ins_left_bits),
    .out_valid_o(io_outs_down_valid),
    .out_ready_i(io_outs_down_ready),
    .out_bits_o (io_outs_down_bits),
    .occ_o      (io_occ_down)
  );

  // LSB chain shifts down by one position; only the tap position is registered.
  logic tap_q, tap_d;
  logic lsb_unused;

  assign tap_d      = io_lsbIns[LSB_TAP+1];
  assign lsb_unused = io_lsbIns[0];

  always_ff @(posedge clock) begin
    if (reset) tap_q <= 1'b0;
    else       tap_q <= tap_d;
  end

  always_comb begin
    io_lsbOuts = '0;
    for (int i = 0; i < LSB_CHAINS-1; i++) begin
      io_lsbOuts[i] = (i == LSB_TAP) ? tap_q : io_lsbIns[i+1];
    end
    io_lsbOuts[LSB_CHAINS-1] = io_outs_left_bits[0];
  end
endmodule

// File: tb/tb_mesh_element_hs.sv
// Bench for mesh_element_hs: per-channel queue reference model with capacity
// DEPTH, directed streaming/back-pressure/reset scenarios and randomized traffic.
module tb_mesh_element_hs;
  localparam int WIDTH      = 64;
  localparam int DEPTH      = 2;
  localparam int LSB_CHAINS = 8;
  localparam int LSB_TAP    = 3;
  localparam int CW         = $clog2(DEPTH+1);

  // Channel index c: 0 down->left, 1 right->up, 2 up->right, 3 left->down.
  logic                  clock = 1'b0;
  logic                  reset;
  logic                  in_valid  [4];
  logic [WIDTH-1:0]      in_bits   [4];
  logic                  out_ready [4];
  logic                  in_ready  [4];
  logic                  out_valid [4];
  logic [WIDTH-1:0]      out_bits  [4];
  logic [CW-1:0]         occ       [4];
  logic [LSB_CHAINS-1:0] lsb_in;
  logic [LSB_CHAINS-1:0] lsb_out;

  logic [WIDTH-1:0] exp_q [4][$];
  logic             tap_m;
  int               n_checks = 0;
  int               n_errors = 0;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  mesh_element_hs #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LSB_CHAINS(LSB_CHAINS), .LSB_TAP(LSB_TAP)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .io_ins_down_valid  (in_valid[0]),
    .io_ins_down_ready  (in_ready[0]),
    .io_ins_down_bits   (in_bits[0]),
    .io_ins_right_valid (in_valid[1]),
    .io_ins_right_ready (in_ready[1]),
    .io_ins_right_bits  (in_bits[1]),
    .io_ins_up_valid    (in_valid[2]),
    .io_ins_up_ready    (in_ready[2]),
    .io_ins_up_bits     (in_bits[2]),
    .io_ins_left_valid  (in_valid[3]),
    .io_ins_left_ready  (in_ready[3]),
    .io_ins_left_bits   (in_bits[3]),
    .io_outs_down_valid (out_valid[3]),
    .io_outs_down_ready (out_ready[3]),
    .io_outs_down_bits  (out_bits[3]),
    .io_outs_right_valid(out_valid[2]),
    .io_outs_right_ready(out_ready[2]),
    .io_outs_right_bits (out_bits[2]),
    .io_outs_up_valid   (out_valid[1]),
    .io_outs_up_ready   (out_ready[1]),
    .io_outs_up_bits    (out_bits[1]),
    .io_outs_left_valid (out_valid[0]),
    .io_outs_left_ready (out_ready[0]),
    .io_outs_left_bits  (out_bits[0]),
    .io_occ_down        (occ[3]),
    .io_occ_right       (occ[2]),
    .io_occ_up          (occ[1]),
    .io_occ_left        (occ[0]),
    .io_lsbIns          (lsb_in),
    .io_lsbOuts         (lsb_out)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("out_valid[%0d]", c), out_valid[c], exp_q[c].size() != 0);
      check($sformatf("in_ready[%0d]", c), in_ready[c], exp_q[c].size() < DEPTH);
      check($sformatf("occ[%0d]", c), occ[c], exp_q[c].size());
      if (exp_q[c].size() > 0)
        check($sformatf("out_bits[%0d]", c), out_bits[c], exp_q[c][0]);
    end
    for (int i = 0; i < LSB_CHAINS-1; i++)
      check($sformatf("lsb_out[%0d]", i), lsb_out[i], (i == LSB_TAP) ? tap_m : lsb_in[i+1]);
    if (exp_q[0].size() > 0)
      check("lsb_out_msb", lsb_out[LSB_CHAINS-1], exp_q[0][0][0]);
  endtask

  // ---------------- driver / model step ----------------
  // Called at a falling edge with inputs already set; advances one clock.
  task automatic tick();
    bit               push [4];
    bit               pop  [4];
    logic [WIDTH-1:0] pb   [4];
    logic             tap_next;
    logic             rst;
    for (int c = 0; c < 4; c++) begin
      pop[c]  = out_ready[c] && (exp_q[c].size() > 0);
      push[c] = in_valid[c] && (exp_q[c].size() < DEPTH);
      pb[c]   = in_bits[c];
    end
    tap_next = lsb_in[LSB_TAP+1];
    rst      = reset;
    @(posedge clock);
    if (rst) begin
      for (int c = 0; c < 4; c++) exp_q[c].delete();
      tap_m = 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (pop[c])  void'(exp_q[c].pop_front());
        if (push[c]) exp_q[c].push_back(pb[c]);
      end
      tap_m = tap_next;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < 4; c++) begin
      in_valid[c]  = 1'b0;
      in_bits[c]   = '0;
      out_ready[c] = 1'b0;
    end
  endtask

  task automatic check_reset_bits(input string tag);
    for (int c = 0; c < 4; c++)
      check($sformatf("%s_bits[%0d]", tag, c), out_bits[c], 64'h0);
    check($sformatf("%s_lsb_msb", tag), lsb_out[LSB_CHAINS-1], 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic accepted;
    tap_m  = 1'b0;
    reset  = 1'b1;
    lsb_in = '0;
    idle_inputs();

    // Reset then idle
    tick();
    tick();
    reset = 1'b0;
    check_reset_bits("rst");
    tick();

    // Streaming on down->left with consumer always ready
    out_ready[0] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid[0] = 1'b1;
      in_bits[0]  = WIDTH'(k);
      tick();
      check("stream_occ_le1", occ[0] <= 1, 1'b1);
    end
    in_valid[0] = 1'b0;
    tick();
    tick();

    // Back-pressure on right->up
    out_ready[1] = 1'b0;
    in_valid[1]  = 1'b1;
    in_bits[1]   = 64'hA;
    tick();
    in_bits[1]   = 64'hB;
    tick();
    in_bits[1]   = 64'hC;
    for (int k = 0; k < 3; k++) tick();
    check("bp_ready", in_ready[1], 1'b0);
    check("bp_occ", occ[1], 2);
    out_ready[1] = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 10 && !accepted; k++) begin
      accepted = in_ready[1];
      tick();
    end
    check("bp_c_accepted", accepted, 1'b1);
    in_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("bp_drained", occ[1], 0);

    // LSB directed: tap one cycle late, others combinational
    lsb_in = '0;
    tick();
    lsb_in[LSB_TAP+1] = 1'b1;
    lsb_in[2]         = 1'b1;
    #1;
    check("lsb_comb_same_cycle", lsb_out[1], 1'b1);
    check("lsb_tap_not_yet", lsb_out[LSB_TAP], 1'b0);
    @(negedge clock);
    tick();
    check("lsb_tap_followed", lsb_out[LSB_TAP], 1'b1);
    in_valid[0]  = 1'b1;
    in_bits[0]   = 64'hFFFF_0000_0000_0001;
    out_ready[0] = 1'b0;
    tick();
    in_valid[0]  = 1'b0;
    check("lsb_msb_one", lsb_out[LSB_CHAINS-1], 1'b1);
    out_ready[0] = 1'b1;
    tick();
    tick();

    // Randomized traffic on all channels simultaneously
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 4; c++) begin
        in_valid[c]  = 1'($urandom_range(0, 1));
        in_bits[c]   = {$urandom, $urandom};
        out_ready[c] = ($urandom_range(0, 3) != 0);
      end
      lsb_in = LSB_CHAINS'($urandom);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) out_ready[c] = 1'b1;
      tick();
    end

    // Reset mid-operation with two buffers full and valids held
    for (int c = 0; c < 4; c++) out_ready[c] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[0] = 1'b1;
      in_bits[0]  = {$urandom, $urandom} | 64'h1;
      in_valid[1] = 1'b1;
      in_bits[1]  = {$urandom, $urandom};
      tick();
    end
    check("pre_rst_occ0", occ[0], DEPTH);
    check("pre_rst_occ1", occ[1], DEPTH);
    reset = 1'b1;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_bits("midrst");
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    for (int k = 0; k < 4; k++) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
